// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one load/store at a time and
// answers with a one-cycle ack after a fixed number of wait states.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         lat_addr;
  logic [DATA_W-1:0]   lat_wd;
  logic                lat_we;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [31:0]         sel_addr_c;
  logic [DATA_W-1:0]   sel_wd_c;
  logic                sel_we_c;
  logic                sel_err_c;
  logic [IDX_W-1:0]    sel_idx_c;
  logic                accept_c;
  logic                enter_resp_c;

  // With zero wait states the accept edge is also the RESP entry edge, so the
  // live inputs stand in for the not-yet-latched request.
  assign sel_addr_c   = (state == IDLE) ? addr : lat_addr;
  assign sel_wd_c     = (state == IDLE) ? wd   : lat_wd;
  assign sel_we_c     = (state == IDLE) ? we   : lat_we;
  assign sel_err_c    = (sel_addr_c[1:0] != 2'b00) ||
                        ({2'b00, sel_addr_c[31:2]} >= 32'(DEPTH));
  assign sel_idx_c    = sel_addr_c[IDX_W+1:2];
  assign accept_c     = (state == IDLE) && req;
  assign enter_resp_c = (accept_c && (WAIT_CYCLES == 0)) ||
                        ((state == BUSY) && (cnt == CNT_W'(0)));

  // Storage is never reset; a store commits on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (reset && enter_resp_c && sel_we_c && !sel_err_c) begin
      mem[sel_idx_c] <= sel_wd_c;
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rd       <= '0;
      busy     <= 1'b0;
      lat_addr <= '0;
      lat_wd   <= '0;
      lat_we   <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      rd  <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= addr;
            lat_wd   <= wd;
            lat_we   <= we;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(0)) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (enter_resp_c) begin
        ack <= 1'b1;
        err <= sel_err_c;
        rd  <= (!sel_we_c && !sel_err_c) ? mem[sel_idx_c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder, one instance with two wait
// states and one with none, checked against a plain array memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        reset0 = 1'b0, reset1 = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] rd0, rd1;
  logic        ack0, ack1, err0, err1, busy0, busy1;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] shadow [2][DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .addr(addr0), .wd(wd0),
    .rd(rd0), .ack(ack0), .err(err0), .busy(busy0));

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .reset(reset1), .req(req1), .we(we1), .addr(addr1), .wd(wd1),
    .rd(rd1), .ack(ack1), .err(err1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] data);
    if (d == 0) begin req0 = r; we0 = w; addr0 = a; wd0 = data; end
    else        begin req1 = r; we1 = w; addr1 = a; wd1 = data; end
  endtask

  // Memory semantics: misaligned or out-of-range -> error, no write, rd=0.
  task automatic model(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] data, output logic e, output logic [31:0] r);
    e = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    r = '0;
    if (!e) begin
      if (w) shadow[d][a[31:2]] = data;
      else   r = shadow[d][a[31:2]];
    end
  endtask

  task automatic chk_out(input int d, input string tag, input logic e_ack,
                         input logic e_busy, input logic e_err, input logic [31:0] e_rd);
    chk({tag, ".ack"},  32'(d ? ack1 : ack0),   32'(e_ack));
    chk({tag, ".busy"}, 32'(d ? busy1 : busy0), 32'(e_busy));
    chk({tag, ".err"},  32'(d ? err1 : err0),   32'(e_err));
    chk({tag, ".rd"},   d ? rd1 : rd0,          e_rd);
  endtask

  // Entered just after a negedge with the DUT idle; returns the same way.
  task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input string tag);
    int wc;
    logic e;
    logic [31:0] r;
    wc = d ? W1 : W0;
    drive(d, 1'b1, w, a, data);
    @(posedge clk);
    model(d, w, a, data, e, r);
    #1 drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int k = 1; k <= wc + 1; k++) begin
      @(negedge clk);
      if (k == wc + 1) begin
        chk_out(d, tag, 1'b1, 1'b1, e, r);
        drive(d, 1'b0, 1'b0, $urandom, $urandom);
      end else begin
        chk_out(d, tag, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
    @(negedge clk);
    chk_out(d, {tag, ".idle"}, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH + 3)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 15) == 0) a = $urandom;
    return a;
  endfunction

  initial begin
    logic [31:0] v1, a, exp_rd;
    logic        e, w, exp_err;
    int          acks;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out(0, "reset0", 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out(1, "reset1", 1'b0, 1'b0, 1'b0, 32'h0);
    reset0 = 1'b1;
    reset1 = 1'b1;

    // Give every word a defined value so loads are predictable.
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_txn(0, 1'b1, 32'(i * 4), $urandom, "init0");
      do_txn(1, 1'b1, 32'(i * 4), $urandom, "init1");
    end

    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, "st10");
    do_txn(0, 1'b0, 32'h10, 32'h0, "ld10");
    chk("ld10.model", shadow[0][4], 32'hDEADBEEF);

    do_txn(0, 1'b0, 32'h13, 32'h0, "ld13_mis");
    do_txn(0, 1'b0, 32'h100, 32'h0, "ld100_oor");
    do_txn(0, 1'b1, 32'h11, 32'h12345678, "st11_mis");
    do_txn(0, 1'b1, 32'h110, 32'h12345678, "st110_oor");
    do_txn(0, 1'b1, 32'hFFFF_FFFC, 32'h12345678, "st_top");
    do_txn(0, 1'b0, 32'h10, 32'h0, "ld10_again");

    // Back-to-back requests with req held high.
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      w = (i % 2 == 0);
      v1 = $urandom;
      drive(0, 1'b1, w, 32'h0, v1);
      @(posedge clk);
      model(0, w, 32'h0, v1, exp_err, exp_rd);
      for (int p = 0; p < W0 + 2; p++) begin
        @(negedge clk);
        if (ack0 === 1'b1) acks++;
        if (p == W0) chk_out(0, "b2b.resp", 1'b1, 1'b1, exp_err, exp_rd);
        else chk_out(0, "b2b", 1'b0, p < W0, 1'b0, 32'h0);
        if (p == W0 + 1) begin
          if (i == 7) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
          else        drive(0, 1'b1, ~w, 32'h0, $urandom);
        end
        if (p < W0 + 1) @(posedge clk);
      end
    end
    chk("b2b.ack_count", 32'(acks), 32'd8);

    // Reset in the second BUSY cycle aborts a store.
    v1 = $urandom;
    do_txn(0, 1'b1, 32'h8, v1, "st8");
    drive(0, 1'b1, 1'b1, 32'h8, ~v1);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk_out(0, "abort.busy2", 1'b0, 1'b1, 1'b0, 32'h0);
    reset0 = 1'b0;
    @(negedge clk);
    chk_out(0, "abort.rst", 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_out(0, "abort.rst2", 1'b0, 1'b0, 1'b0, 32'h0);
    reset0 = 1'b1;
    do_txn(0, 1'b0, 32'h8, 32'h0, "ld8_after_abort");
    chk("ld8.model", shadow[0][2], v1);

    // Zero wait states: ack and busy for exactly the cycle after accept.
    do_txn(1, 1'b0, 32'h4, 32'h0, "w0.ld4");
    do_txn(1, 1'b1, 32'h4, 32'hCAFEF00D, "w0.st4");
    do_txn(1, 1'b0, 32'h4, 32'h0, "w0.ld4b");
    do_txn(1, 1'b0, 32'h102, 32'h0, "w0.err");

    for (int i = 0; i < 40; i++) begin
      a = rand_addr();
      e = 1'($urandom_range(0, 1));
      do_txn(0, e, a, $urandom, "rnd0");
      a = rand_addr();
      e = 1'($urandom_range(0, 1));
      do_txn(1, e, a, $urandom, "rnd1");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, number of 32-bit words in the storage array.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each response (legal range 0-15).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-low reset; sampled on rising clk edge, asserted when 0.
REQ-005 The block SHALL have port req, input, 1, initiator request; addr/we/wd valid whenever req=1.
REQ-006 The block SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port addr, input, 32, byte address; word index = addr[31:2].
REQ-008 The block SHALL have port wd, input, 32, store data.
REQ-009 The block SHALL have port rd, output, 32, load data, valid while ack=1.
REQ-010 The block SHALL have port ack, output, 1, single-cycle response strobe.
REQ-011 The block SHALL have port err, output, 1, error flag, meaningful only while ack=1.
REQ-012 The block SHALL have port busy, output, 1, high while a request is in flight (BUSY or RESP state).

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-014 In IDLE with req=1 at a rising edge, the block SHALL latch addr, we, wd and leave IDLE (the accept edge).
REQ-015 At the accept edge the block SHALL go to BUSY with the wait counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0, else go directly to RESP.
REQ-016 In BUSY the counter SHALL decrement once per cycle; at the edge where it equals 0 the FSM SHALL move to RESP.
REQ-017 ack SHALL be 1 for exactly one cycle (the RESP cycle), WAIT_CYCLES+1 cycles after the accept edge.
REQ-018 RESP SHALL always return to IDLE on the next edge.
REQ-019 Throughput SHALL be one request per WAIT_CYCLES+2 cycles when req is held high continuously.
REQ-020 A request SHALL be erroneous if addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-021 A valid store SHALL write the latched wd to the latched word index at the edge entering RESP.
REQ-022 For a valid load, rd SHALL equal the array word at the latched index, sampled at the edge entering RESP.
REQ-023 For stores and errors, rd SHALL be 0 during the RESP cycle.
REQ-024 An erroneous request SHALL assert err=1 with ack, SHALL perform no write, and SHALL return rd=0.
REQ-025 req, addr, we and wd SHALL be ignored in BUSY and RESP; changing them mid-transaction SHALL have no effect.
REQ-026 A load following a store to the same word SHALL return the stored data.
REQ-027 The block SHALL hold rd and err at 0 whenever ack=0.
REQ-028 busy SHALL be 1 from the cycle after the accept edge through the RESP cycle inclusive.

Reset
REQ-029 While reset=0 at a rising edge, the FSM SHALL go to IDLE with counter=0, ack=0, err=0, rd=0 and busy=0.
REQ-030 Reset during BUSY SHALL abort the transaction: no write occurs and no ack is issued.
REQ-031 Reset in the RESP cycle SHALL clear the outputs on the next edge; a write committed at RESP entry SHALL persist.
REQ-032 The storage array contents SHALL NOT be affected by reset.
REQ-033 A request presented in the first cycle after reset release SHALL be accepted normally.

Verification
REQ-034 With WAIT_CYCLES=2, store addr=0x10, wd=0xDEADBEEF, then load addr=0x10 -> each ack arrives 3 cycles after its accept edge; the load returns rd=0xDEADBEEF with err=0.
REQ-035 Load addr=0x13 (misaligned) and addr=0x100 (index 64>=DEPTH) -> ack with err=1 and rd=0; word 4 is unchanged.
REQ-036 req held high with alternating store/load to addr=0x0 -> ack every 4 cycles; no request is lost or duplicated.
REQ-037 Store to addr=0x8 with reset=0 asserted in the second BUSY cycle -> no ack; a subsequent load of 0x8 returns the prior value.
REQ-038 Change addr and wd while busy=1 -> response reflects the originally latched values only.
REQ-039 With WAIT_CYCLES=0, load addr=0x4 -> ack in the cycle immediately after the accept edge; busy is high for exactly 1 cycle.
